// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - score to BCD converter and digitDraw sequencer with 2-stage VGA plot pipeline
module score_display_ctrl #(
    parameter int         NUM_DIGITS  = 4,
    parameter int         SCORE_W     = 14,
    parameter logic [7:0] X0          = 8'd100,
    parameter logic [7:0] Y0          = 8'd2,
    parameter logic [7:0] DIGIT_PITCH = 8'd15,
    parameter bit         BLANK_LZ    = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    output logic               score_ready,
    output logic               busy,
    output logic               done,
    output logic               dd_rst,
    output logic               dd_en,
    output logic [3:0]         dd_sel,
    output logic [7:0]         dd_x,
    output logic [7:0]         dd_y,
    input  logic               dd_end,
    input  logic [7:0]         dd_x_draw,
    input  logic [7:0]         dd_y_draw,
    input  logic [23:0]        dd_colour,
    output logic [7:0]         vga_x,
    output logic [7:0]         vga_y,
    output logic [23:0]        vga_colour,
    output logic               vga_plot
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint unsigned    MAX_SCORE = pow10(NUM_DIGITS) - 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]   CONV_LAST = CNT_W'(SCORE_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_LOAD, S_DRAW, S_DRAIN, S_DONE} state_t;

    state_t             state, state_nx;
    logic [SCORE_W-1:0] shreg;
    logic [SCORE_W-1:0] score_sat;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               v1;
    logic [7:0]         x1, y1;
    logic [3:0]         digit;
    logic [3:0]         nib;
    logic               blank;
    logic               lead_zero;

    assign score_sat = (64'(score) > MAX_SCORE) ? SCORE_W'(MAX_SCORE) : score;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // Index 0 is the most significant digit; a digit stays blank while every digit up to it is zero.
    always_comb begin
        lead_zero = BLANK_LZ;
        digit     = 4'd0;
        blank     = 1'b0;
        nib       = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = bcd[4*(NUM_DIGITS-1-i) +: 4];
            if (nib != 4'd0) lead_zero = 1'b0;
            if (IDX_W'(i) == idx) begin
                digit = nib;
                blank = lead_zero && (i != NUM_DIGITS - 1);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        score_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        dd_rst      = 1'b0;
        dd_en       = 1'b0;
        dd_sel      = 4'd0;
        dd_x        = 8'd0;
        dd_y        = 8'd0;
        if (state == S_LOAD || state == S_DRAW) begin
            dd_sel = blank ? 4'hF : digit;
            dd_x   = X0 + 8'(idx) * DIGIT_PITCH;
            dd_y   = Y0;
        end
        case (state)
            S_IDLE: begin
                busy        = 1'b0;
                score_ready = 1'b1;
                if (score_valid) state_nx = S_CONV;
            end
            S_CONV:  if (cnt == CONV_LAST) state_nx = S_LOAD;
            S_LOAD: begin
                dd_rst   = 1'b1;
                state_nx = S_DRAW;
            end
            S_DRAW: begin
                dd_en = ~dd_end;
                if (dd_end) state_nx = (idx == LAST_IDX) ? S_DRAIN : S_LOAD;
            end
            S_DRAIN: if (cnt == CNT_W'(1)) state_nx = S_DONE;
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bcd        <= '0;
            idx        <= '0;
            cnt        <= '0;
            v1         <= 1'b0;
            x1         <= 8'd0;
            y1         <= 8'd0;
            vga_plot   <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 8'd0;
            vga_colour <= 24'd0;
        end else begin
            state <= state_nx;
            // Stage 1 holds the address while the ROM read completes; stage 2 pairs it with the data.
            v1         <= (state == S_DRAW) & ~dd_end;
            x1         <= dd_x_draw;
            y1         <= dd_y_draw;
            vga_plot   <= v1;
            vga_x      <= x1;
            vga_y      <= y1;
            vga_colour <= dd_colour;
            case (state)
                S_IDLE: if (score_valid) begin
                    shreg <= score_sat;
                    bcd   <= '0;
                    cnt   <= '0;
                end
                S_CONV: begin
                    {bcd, shreg} <= {bcd_adj, shreg} << 1;
                    cnt          <= cnt + 1'b1;
                    idx          <= '0;
                end
                S_DRAW: if (dd_end) begin
                    if (idx == LAST_IDX) cnt <= '0;
                    else                 idx <= idx + 1'b1;
                end
                S_DRAIN: cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - scoreboard bench for score_display_ctrl with behavioural digitDraw models
module tb_score_display_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: BLANK_LZ=1, instance B: BLANK_LZ=0
    logic [13:0] score_a = '0, score_b = '0;
    logic        sv_a = 1'b0, sv_b = 1'b0;
    logic        sr_a, busy_a, done_a, rst_a, en_a, end_a, vp_a;
    logic        sr_b, busy_b, done_b, rst_b, en_b, end_b, vp_b;
    logic [3:0]  sel_a, sel_b;
    logic [7:0]  x_a, y_a, xd_a, yd_a, vx_a, vy_a;
    logic [7:0]  x_b, y_b, xd_b, yd_b, vx_b, vy_b;
    logic [23:0] col_a, vc_a, col_b, vc_b;
    logic [7:0]  cnt_a, cnt_b;

    score_display_ctrl dut_a (
        .clk(clk), .resetn(resetn), .score(score_a), .score_valid(sv_a), .score_ready(sr_a),
        .busy(busy_a), .done(done_a), .dd_rst(rst_a), .dd_en(en_a), .dd_sel(sel_a),
        .dd_x(x_a), .dd_y(y_a), .dd_end(end_a), .dd_x_draw(xd_a), .dd_y_draw(yd_a),
        .dd_colour(col_a), .vga_x(vx_a), .vga_y(vy_a), .vga_colour(vc_a), .vga_plot(vp_a)
    );

    score_display_ctrl #(.BLANK_LZ(1'b0)) dut_b (
        .clk(clk), .resetn(resetn), .score(score_b), .score_valid(sv_b), .score_ready(sr_b),
        .busy(busy_b), .done(done_b), .dd_rst(rst_b), .dd_en(en_b), .dd_sel(sel_b),
        .dd_x(x_b), .dd_y(y_b), .dd_end(end_b), .dd_x_draw(xd_b), .dd_y_draw(yd_b),
        .dd_colour(col_b), .vga_x(vx_b), .vga_y(vy_b), .vga_colour(vc_b), .vga_plot(vp_b)
    );

    function automatic logic [23:0] rom(input logic [3:0] s, input logic [7:0] a);
        return {s, 4'h0, a, a ^ 8'hA5};
    endfunction

    // digitDraw: 14x15 raster counter, end after 210 pixels, ROM data one cycle after address
    always @(posedge clk) begin
        if (!resetn || rst_a) cnt_a <= 8'd0;
        else if (en_a && cnt_a != 8'd210) cnt_a <= cnt_a + 8'd1;
        col_a <= rom(sel_a, cnt_a);
        if (!resetn || rst_b) cnt_b <= 8'd0;
        else if (en_b && cnt_b != 8'd210) cnt_b <= cnt_b + 8'd1;
        col_b <= rom(sel_b, cnt_b);
    end
    assign end_a = (cnt_a == 8'd210);
    assign xd_a  = x_a + 8'(cnt_a % 8'd14);
    assign yd_a  = y_a + 8'(cnt_a / 8'd14);
    assign end_b = (cnt_b == 8'd210);
    assign xd_b  = x_b + 8'(cnt_b % 8'd14);
    assign yd_b  = y_b + 8'(cnt_b / 8'd14);

    logic [19:0] q_sel_a[$], q_sel_b[$];
    logic [39:0] q_pix_a[$];
    logic [19:0] e_sel_a, e_sel_b;
    logic [39:0] e_pix_a;
    int done_cnt_a = 0, done_cnt_b = 0, done_cyc_a = 0, done_cyc_b = 0, load_cnt_a = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_a === 1'b1) begin
            load_cnt_a++;
            checks++;
            if (q_sel_a.size() == 0) begin
                errors++;
                $error("FAIL sel_a_unexpected: got sel=%h x=%0d y=%0d expected none", sel_a, x_a, y_a);
            end else begin
                e_sel_a = q_sel_a.pop_front();
                assert ({sel_a, x_a, y_a} === e_sel_a) else begin
                    errors++;
                    $error("FAIL sel_a: got %h expected %h", {sel_a, x_a, y_a}, e_sel_a);
                end
            end
        end
        if (vp_a === 1'b1) begin
            checks++;
            if (q_pix_a.size() == 0) begin
                errors++;
                $error("FAIL pix_a_unexpected: got %h expected none", {vx_a, vy_a, vc_a});
            end else begin
                e_pix_a = q_pix_a.pop_front();
                assert ({vx_a, vy_a, vc_a} === e_pix_a) else begin
                    errors++;
                    $error("FAIL pix_a: got %h expected %h", {vx_a, vy_a, vc_a}, e_pix_a);
                end
            end
        end
        if (done_a === 1'b1) begin done_cnt_a++; done_cyc_a = cyc; end
        if (rst_b === 1'b1) begin
            checks++;
            if (q_sel_b.size() == 0) begin
                errors++;
                $error("FAIL sel_b_unexpected: got sel=%h expected none", sel_b);
            end else begin
                e_sel_b = q_sel_b.pop_front();
                assert ({sel_b, x_b, y_b} === e_sel_b) else begin
                    errors++;
                    $error("FAIL sel_b: got %h expected %h", {sel_b, x_b, y_b}, e_sel_b);
                end
            end
        end
        if (done_b === 1'b1) begin done_cnt_b++; done_cyc_b = cyc; end
    end

    task automatic expect_req(input int s, input bit blz, input bit inst_b);
        int sat, pw, d, sel;
        bit nz;
        sat = (s > 9999) ? 9999 : s;
        pw = 1000;
        nz = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d  = (sat / pw) % 10;
            pw = pw / 10;
            if (d != 0) nz = 1'b1;
            sel = (blz && !nz && i != 3) ? 15 : d;
            if (inst_b) q_sel_b.push_back({4'(sel), 8'(100 + 15 * i), 8'd2});
            else begin
                q_sel_a.push_back({4'(sel), 8'(100 + 15 * i), 8'd2});
                for (int k = 0; k < 210; k++)
                    q_pix_a.push_back({8'(100 + 15 * i + k % 14), 8'(2 + k / 14), rom(4'(sel), 8'(k))});
            end
        end
    endtask

    task automatic req_a(input int s, input bit pulse);
        int start, acc;
        expect_req(s, 1'b1, 1'b0);
        start   = done_cnt_a;
        score_a = 14'(s);
        sv_a    = 1'b1;
        @(negedge clk);
        chk("ready_at_accept", int'(sr_a), 1);
        acc = cyc;
        @(posedge clk); #1;
        sv_a    = 1'b0;
        score_a = '0;
        if (pulse) begin
            repeat (300) @(posedge clk);
            #1;
            sv_a    = 1'b1;
            score_a = 14'd5;
            @(negedge clk);
            chk("ready_while_busy", int'(sr_a), 0);
            chk("busy_mid_draw", int'(busy_a), 1);
            @(posedge clk); #1;
            sv_a = 1'b0;
        end
        for (int i = 0; i < 2000 && done_cnt_a == start; i++) @(negedge clk);
        chk("done_seen", done_cnt_a, start + 1);
        chk("latency", done_cyc_a - acc, 865);
        repeat (20) @(negedge clk);
        chk("done_once", done_cnt_a, start + 1);
        chk("sel_q_drained", q_sel_a.size(), 0);
        chk("pix_q_drained", q_pix_a.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, acc;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_a_ctrl", int'({sr_a, busy_a, done_a, rst_a, en_a, sel_a, vp_a}), 'b1_0_0_0_0_0000_0);
        chk("reset_a_vga", int'({vx_a, vy_a}), 0);
        chk("reset_a_colour", int'(vc_a), 0);
        chk("reset_a_xy", int'({x_a, y_a}), 0);
        chk("reset_b_ctrl", int'({sr_b, busy_b, done_b, rst_b, en_b, sel_b, vp_b}), 'b1_0_0_0_0_0000_0);
        @(posedge clk); #1;
        resetn = 1'b1;

        req_a(1234, 1'b1);
        req_a(7, 1'b0);
        req_a(0, 1'b0);
        req_a(12000, 1'b0);
        req_a(10000, 1'b0);
        req_a(9999, 1'b0);

        // BLANK_LZ=0 instance keeps leading zeros numeric
        expect_req(7, 1'b0, 1'b1);
        start   = done_cnt_b;
        score_b = 14'd7;
        sv_b    = 1'b1;
        @(negedge clk);
        acc = cyc;
        @(posedge clk); #1;
        sv_b = 1'b0;
        for (int i = 0; i < 2000 && done_cnt_b == start; i++) @(negedge clk);
        chk("b_done_seen", done_cnt_b, start + 1);
        chk("b_latency", done_cyc_b - acc, 865);
        chk("b_sel_q_drained", q_sel_b.size(), 0);
        @(posedge clk); #1;

        // reset in the middle of digit 2
        expect_req(5678, 1'b1, 1'b0);
        start   = done_cnt_a;
        acc     = load_cnt_a;
        score_a = 14'd5678;
        sv_a    = 1'b1;
        @(posedge clk); #1;
        sv_a = 1'b0;
        for (int i = 0; i < 1000 && load_cnt_a < acc + 3; i++) @(negedge clk);
        chk("reached_digit2", load_cnt_a, acc + 3);
        repeat (50) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        q_sel_a.delete();
        q_pix_a.delete();
        @(negedge clk);
        chk("midreset_ctrl", int'({sr_a, busy_a, done_a, en_a, vp_a}), 'b1_0_0_0_0);
        for (int i = 0; i < 1000; i++) @(negedge clk);
        chk("midreset_no_done", done_cnt_a, start);
        @(posedge clk); #1;
        req_a(4321, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
